// File: rtl/rom_read_arbiter_if.sv
// Bundle of requester, response and ROM-side signals shared by the ROM read arbiter.
// Latency: none, wires only.
// Backpressure: none; requesters hold req level until served or withdrawn.
interface rom_read_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              grant0;
  logic              valid0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              grant1;
  logic              valid1;
  logic [DATA_W-1:0] data1;
  logic [ADDR_W-1:0] ROM_addr;
  logic [DATA_W-1:0] ROM_data;
  logic              busy;

  // Arbiter side: sees requests and ROM data, drives grants, responses and ROM address.
  modport slave (
    input  req0, addr0, req1, addr1, ROM_data,
    output grant0, valid0, data0, grant1, valid1, data1, ROM_addr, busy
  );

  // Environment side: requesters plus the ROM itself.
  modport master (
    output req0, addr0, req1, addr1, ROM_data,
    input  grant0, valid0, data0, grant1, valid1, data1, ROM_addr, busy
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin sharing of one combinational ROM between two requesters.
// Latency: grant at sampling edge E0, valid strobe after E0+WAIT_CYCLES, one read per WAIT_CYCLES+2 cycles.
// Backpressure: requests are only sampled in IDLE; a waiting requester simply keeps req high.
module rom_read_arbiter #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  rom_read_arbiter_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Owner of the current read; also remembers the last winner for the round-robin tie-break.
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              valid0_q, valid0_d;
  logic              valid1_q, valid1_d;
  logic              busy_q, busy_d;
  logic              pick1;

  // Requester 1 wins when it is alone, or when both ask and requester 0 won last time.
  always_comb begin
    pick1 = bus.req1 & (~bus.req0 | ~last_owner_q);
  end

  // Next-state logic for the IDLE -> WAIT -> RESP read sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    rom_addr_d   = rom_addr_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    grant0_d     = grant0_q;
    grant1_d     = grant1_q;
    valid0_d     = valid0_q;
    valid1_d     = valid1_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          last_owner_d = pick1;
          rom_addr_d   = pick1 ? bus.addr1 : bus.addr0;
          grant0_d     = ~pick1;
          grant1_d     = pick1;
          cnt_d        = CNT_W'(WAIT_CYCLES);
          busy_d       = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (last_owner_q) begin
            data1_d  = bus.ROM_data;
            valid1_d = 1'b1;
          end else begin
            data0_d  = bus.ROM_data;
            valid0_d = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        valid0_d = 1'b0;
        valid1_d = 1'b0;
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
      rom_addr_q   <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      rom_addr_q   <= rom_addr_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ROM_addr = rom_addr_q;
  assign bus.data0    = data0_q;
  assign bus.data1    = data1_q;
  assign bus.grant0   = grant0_q;
  assign bus.grant1   = grant1_q;
  assign bus.valid0   = valid0_q;
  assign bus.valid1   = valid1_q;
  assign bus.busy     = busy_q;

endmodule
